mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port, 32-bit, big-endian byte-addressed `memory` between two requesters.
//  - Instruction fetch (I, read-only).
//  - Data load/store (D).
//  Picks one requester per cycle, drives the memory port, and converts D byte-enables into
//  the memory's 32-bit write mask. Returns read data one cycle later, registered.
//  Sits between the CPU fetch/LSU stages and `memory`.
// PARAMETERS
//  M         10  log2 of memory word count; memory address width is 2+M bits.
//  MAX_DSTRK 3   max consecutive D grants while I is pending; the next grant then goes to I.
// PORTS
//  clk          input   1     clock, all state updates on posedge
//  rst_n        input   1     asynchronous reset, active-low
//  i_req        input   1     fetch request; held high until i_gnt
//  i_addr       input   2+M   fetch byte address
//  i_gnt        output  1     fetch accepted this cycle (combinational)
//  i_rvalid     output  1     i_rdata valid (pulse, 1 cycle after i_gnt)
//  i_rdata      output  32    fetched word
//  i_err        output  1     with i_rvalid: misaligned fetch, i_rdata=0
//  d_req        input   1     data request; held high, with stable fields, until d_gnt
//  d_we         input   1     1=store, 0=load
//  d_addr       input   2+M   data byte address
//  d_be         input   4     byte enables; d_be[3] -> byte at d_addr+0 (mask[31:24])
//  d_wdata      input   32    store data, big-endian lane order as memory
//  d_gnt        output  1     data accepted this cycle (combinational)
//  d_rvalid     output  1     load data / store ack valid (pulse, 1 cycle after d_gnt)
//  d_rdata      output  32    loaded word (0 for stores)
//  d_err        output  1     with d_rvalid: misaligned access, no memory write done
//  mem_address  output  2+M   to memory.address
//  mem_mask     output  32    to memory.mask
//  mem_wf       output  1     to memory.wf
//  mem_w        output  32    to memory.w
//  mem_v        input   32    from memory.v (combinational read)
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; streak counter = 0.
//   - i_gnt, d_gnt, mem_wf forced 0 while rst_n low, so no writes occur during reset.
//  Grant, combinational in cycle T, at most one of i_gnt/d_gnt:
//   - Only d_req: D wins. Only i_req: I wins. Neither: no grant, mem_wf=0, mem_address=0.
//   - Both: D wins unless streak==MAX_DSTRK, in which case I wins.
//  Streak counter:
//   - +1 on a D grant while i_req=1, saturating at MAX_DSTRK.
//   - Cleared on any I grant, or on a cycle where i_req=0.
//  Memory drive:
//   - mem_address = winner's address.
//   - mem_wf = d_gnt & d_we & ~misaligned.
//   - mem_mask = {{8{d_be[3]}},{8{d_be[2]}},{8{d_be[1]}},{8{d_be[0]}}} on a D grant, else 0.
//   - mem_w = d_wdata.
//  Misaligned: addr[1:0]!=0.
//   - Request is still granted and consumed; no write; err=1, rdata=0 at response.
//  Response, registered at the posedge ending T:
//   - Winner's rvalid=1 in T+1 only. rdata = mem_v sampled at T (loads/fetches); stores give rdata=0.
//   - Loser and idle port: rvalid=0.
//   - rdata holds its last value when rvalid=0.
//  Back-to-back:
//   - A new grant is allowed every cycle; pipelining depth is 1.
//   - Store at T then load of the same word at T+1: the load returns the post-write value.
//  Address width: ports are exactly 2+M bits, no truncation. Top-word accesses must be aligned
//   (enforced by the misalign rule).
//  Reset mid-operation: a pending rvalid is dropped. The requester must re-issue after rst_n rises.
// TESTING
//  1. Reset: rst_n=0 with d_req=1, d_we=1 -> mem_wf=0, all outputs 0. Release -> first grant next edge.
//  2. Store d_addr=0x10, d_be=4'b0011, d_wdata=0xAABBCCDD over mem 0x11223344
//     -> mem_mask=0x0000FFFF, d_rvalid next cycle; load 0x10 returns 0x1122CCDD.
//  3. i_req and d_req held high 8 cycles, MAX_DSTRK=3 -> grants D,D,D,I,D,D,D,I.
//     i_rvalid/d_rvalid each exactly 1 cycle after their own grant.
//  4. Misaligned store d_addr=0x12 -> mem_wf=0, d_err=1 and d_rdata=0 next cycle, memory unchanged.
//     Misaligned fetch i_addr=0x1 -> i_err=1.
//  5. Back-to-back: store 0x5A5A5A5A to 0x20 in cycle T, load 0x20 in T+1 -> d_rdata=0x5A5A5A5A in T+2.
//  6. rst_n pulsed low in the cycle after a load grant -> d_rvalid stays 0; streak counter reads 0 after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, big-endian, byte-addressed memory between
// an instruction-fetch requester (read-only) and a data load/store requester.
// Grants are combinational and the response is registered one cycle later.
// D normally wins a conflict. After MAX_DSTRK consecutive D grants while I waits,
// the next conflicting grant goes to I.
module mem_arbiter #(
    parameter int M         = 10,
    parameter int MAX_DSTRK = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_req,
    input  logic [2+M-1:0] i_addr,
    output logic           i_gnt,
    output logic           i_rvalid,
    output logic [31:0]    i_rdata,
    output logic           i_err,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [2+M-1:0] d_addr,
    input  logic [3:0]     d_be,
    input  logic [31:0]    d_wdata,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [31:0]    d_rdata,
    output logic           d_err,
    output logic [2+M-1:0] mem_address,
    output logic [31:0]    mem_mask,
    output logic           mem_wf,
    output logic [31:0]    mem_w,
    input  logic [31:0]    mem_v
);

    localparam int AW = 2 + M;
    // Streak counter is wide enough to hold MAX_DSTRK; never narrower than one bit.
    localparam int SW = (MAX_DSTRK < 1) ? 1 : $clog2(MAX_DSTRK + 1);
    localparam logic [SW-1:0] STRK_MAX = SW'(MAX_DSTRK);
    localparam logic [SW-1:0] STRK_ONE = SW'(32'd1);

    // Byte enables expand to a bit mask. be[3] selects the lowest-addressed byte,
    // which sits in the most significant lane of a big-endian word.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Any byte offset inside the word makes a word access misaligned.
    function automatic logic is_misaligned(input logic [AW-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic          i_gnt_s;
    logic          d_gnt_s;
    logic          i_mis_s;
    logic          d_mis_s;
    logic [SW-1:0] streak_r;
    logic [SW-1:0] streak_nxt_s;
    logic          i_rvalid_r;
    logic          i_err_r;
    logic [31:0]   i_rdata_r;
    logic          d_rvalid_r;
    logic          d_err_r;
    logic [31:0]   d_rdata_r;

    assign i_mis_s = is_misaligned(i_addr);
    assign d_mis_s = is_misaligned(d_addr);

    // Arbitration. No grant is issued while reset is asserted.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst_n) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (d_req && i_req) begin
            if (streak_r == STRK_MAX) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Next streak value. It counts D grants that make a pending fetch wait.
    always_comb begin
        streak_nxt_s = streak_r;
        if (!i_req || i_gnt_s) begin
            streak_nxt_s = {SW{1'b0}};
        end else if (d_gnt_s) begin
            if (streak_r == STRK_MAX) begin
                streak_nxt_s = streak_r;
            end else begin
                streak_nxt_s = streak_r + STRK_ONE;
            end
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Streak counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= {SW{1'b0}};
        end else begin
            streak_r <= streak_nxt_s;
        end
    end

    // Memory port drive for the current winner. An idle cycle parks the address at 0.
    always_comb begin
        mem_address = {AW{1'b0}};
        mem_mask    = 32'h0000_0000;
        mem_wf      = 1'b0;
        if (d_gnt_s) begin
            mem_address = d_addr;
            mem_mask    = be_to_mask(d_be);
            mem_wf      = d_we & ~d_mis_s;
        end else if (i_gnt_s) begin
            mem_address = i_addr;
            mem_mask    = 32'h0000_0000;
            mem_wf      = 1'b0;
        end else begin
            mem_address = {AW{1'b0}};
            mem_mask    = 32'h0000_0000;
            mem_wf      = 1'b0;
        end
    end

    assign mem_w = d_wdata;
    assign i_gnt = i_gnt_s;
    assign d_gnt = d_gnt_s;

    // Fetch response: one-cycle pulse after a grant. Data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_r <= 1'b0;
            i_err_r    <= 1'b0;
            i_rdata_r  <= 32'h0000_0000;
        end else begin
            i_rvalid_r <= i_gnt_s;
            i_err_r    <= i_gnt_s & i_mis_s;
            if (i_gnt_s) begin
                i_rdata_r <= i_mis_s ? 32'h0000_0000 : mem_v;
            end else begin
                i_rdata_r <= i_rdata_r;
            end
        end
    end

    // Data response: loads return the word, stores and faulted accesses return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rvalid_r <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= 32'h0000_0000;
        end else begin
            d_rvalid_r <= d_gnt_s;
            d_err_r    <= d_gnt_s & d_mis_s;
            if (d_gnt_s) begin
                d_rdata_r <= (d_we || d_mis_s) ? 32'h0000_0000 : mem_v;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign i_rvalid = i_rvalid_r;
    assign i_err    = i_err_r;
    assign i_rdata  = i_rdata_r;
    assign d_rvalid = d_rvalid_r;
    assign d_err    = d_err_r;
    assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small behavioural
// memory behind the arbiter's memory port.
module tb_mem_arbiter;

    localparam int M  = 10;
    localparam int AW = 2 + M;

    logic          clk;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_mask;
    logic          mem_wf;
    logic [31:0]   mem_w;
    logic [31:0]   mem_v;

    logic [31:0]   mem [0:(1<<M)-1];
    logic          ld_en;
    logic [M-1:0]  ld_idx;
    logic [31:0]   ld_val;

    int checks   = 0;
    int failures = 0;
    logic exp_d;
    logic prev_d;
    logic prev_i;

    mem_arbiter #(.M(M), .MAX_DSTRK(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_mask(mem_mask), .mem_wf(mem_wf),
        .mem_w(mem_w), .mem_v(mem_v)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, masked write on posedge, preload port.
    assign mem_v = mem[mem_address[AW-1:2]];
    always @(posedge clk) begin
        if (mem_wf) begin
            mem[mem_address[AW-1:2]] <= (mem[mem_address[AW-1:2]] & ~mem_mask) | (mem_w & mem_mask);
        end else if (ld_en) begin
            mem[ld_idx] <= ld_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_be    = be;
        d_wdata = wd;
    endtask

    task automatic preload(input logic [M-1:0] idx, input logic [31:0] val);
        @(negedge clk);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = 12'h000;
        ld_en = 1'b0; ld_idx = 10'd0; ld_val = 32'h0;
        drive_d(1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);

        // Reset with a store pending: nothing is granted or written.
        preload(10'd0,  32'h0102_0304);
        preload(10'd4,  32'h1122_3344);
        preload(10'd8,  32'h0000_0000);
        preload(10'd16, 32'hCAFE_F00D);
        preload(10'd17, 32'h0BAD_BEEF);
        @(negedge clk);
        ld_en = 1'b0;
        chk("rst_wf", {31'd0, mem_wf}, 32'd0);
        chk("rst_dgnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_ignt", {31'd0, i_gnt}, 32'd0);
        chk("rst_drv", {31'd0, d_rvalid}, 32'd0);
        chk("rst_irv", {31'd0, i_rvalid}, 32'd0);
        chk("rst_drd", d_rdata, 32'd0);
        chk("rst_ird", i_rdata, 32'd0);
        chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);

        // Release with a load pending: granted immediately, data next cycle.
        d_we = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_dgnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("rel_drv", {31'd0, d_rvalid}, 32'd1);
        chk("rel_drd", d_rdata, 32'h1122_3344);

        // Partial store then load of the same word.
        @(posedge clk); #1;
        drive_d(1'b1, 12'h010, 4'b0011, 32'hAABB_CCDD);
        @(negedge clk);
        chk("st_gnt", {31'd0, d_gnt}, 32'd1);
        chk("st_mask", mem_mask, 32'h0000_FFFF);
        chk("st_wf", {31'd0, mem_wf}, 32'd1);
        @(posedge clk); #1;
        drive_d(1'b0, 12'h010, 4'hF, 32'h0);
        @(negedge clk);
        chk("st_ack", {31'd0, d_rvalid}, 32'd1);
        chk("st_ackdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("ld_rv", {31'd0, d_rvalid}, 32'd1);
        chk("ld_data", d_rdata, 32'h1122_CCDD);
        @(posedge clk);
        @(negedge clk);
        chk("idle_rv", {31'd0, d_rvalid}, 32'd0);
        chk("idle_hold", d_rdata, 32'h1122_CCDD);

        // Contention: expect D,D,D,I repeating.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 12'h040;
        drive_d(1'b0, 12'h044, 4'hF, 32'h0);
        prev_d = 1'b0; prev_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_d = ((k % 4) != 3);
            chk($sformatf("ct_dgnt%0d", k), {31'd0, d_gnt}, {31'd0, exp_d});
            chk($sformatf("ct_ignt%0d", k), {31'd0, i_gnt}, {31'd0, ~exp_d});
            chk($sformatf("ct_drv%0d", k), {31'd0, d_rvalid}, {31'd0, prev_d});
            chk($sformatf("ct_irv%0d", k), {31'd0, i_rvalid}, {31'd0, prev_i});
            if (prev_d) chk($sformatf("ct_drd%0d", k), d_rdata, 32'h0BAD_BEEF);
            if (prev_i) chk($sformatf("ct_ird%0d", k), i_rdata, 32'hCAFE_F00D);
            prev_d = exp_d;
            prev_i = ~exp_d;
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("ct_last_irv", {31'd0, i_rvalid}, 32'd1);
        chk("ct_last_drv", {31'd0, d_rvalid}, 32'd0);

        // Misaligned store and fetch.
        @(posedge clk); #1;
        drive_d(1'b1, 12'h012, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("mis_dgnt", {31'd0, d_gnt}, 32'd1);
        chk("mis_wf", {31'd0, mem_wf}, 32'd0);
        @(posedge clk); #1;
        d_req = 1'b0; i_req = 1'b1; i_addr = 12'h001;
        @(negedge clk);
        chk("mis_drv", {31'd0, d_rvalid}, 32'd1);
        chk("mis_derr", {31'd0, d_err}, 32'd1);
        chk("mis_drd", d_rdata, 32'h0);
        chk("mis_ignt", {31'd0, i_gnt}, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
        drive_d(1'b0, 12'h010, 4'hF, 32'h0);
        @(negedge clk);
        chk("mis_irv", {31'd0, i_rvalid}, 32'd1);
        chk("mis_ierr", {31'd0, i_err}, 32'd1);
        chk("mis_ird", i_rdata, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("mis_unch", d_rdata, 32'h1122_CCDD);
        chk("mis_derr0", {31'd0, d_err}, 32'd0);

        // Back-to-back store then load of the same word.
        @(posedge clk); #1;
        drive_d(1'b1, 12'h020, 4'hF, 32'h5A5A_5A5A);
        @(negedge clk);
        chk("b2b_wf", {31'd0, mem_wf}, 32'd1);
        @(posedge clk); #1;
        drive_d(1'b0, 12'h020, 4'hF, 32'h0);
        @(negedge clk);
        chk("b2b_ack", d_rdata, 32'h0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("b2b_rd", d_rdata, 32'h5A5A_5A5A);

        // Reset pulse right after a load grant, with the streak at its limit.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 12'h040;
        drive_d(1'b0, 12'h044, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rp_dgnt%0d", k), {31'd0, d_gnt}, 32'd1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        chk("rp_drv_low", {31'd0, d_rvalid}, 32'd0);
        chk("rp_drd_low", d_rdata, 32'h0);
        chk("rp_gnt_low", {30'd0, i_gnt, d_gnt}, 32'd0);
        chk("rp_wf_low", {31'd0, mem_wf}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rp_streak0", {30'd0, i_gnt, d_gnt}, 32'd1);
        chk("rp_drv", {31'd0, d_rvalid}, 32'd0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rp_reissue_rv", {31'd0, d_rvalid}, 32'd1);
        chk("rp_reissue_rd", d_rdata, 32'h0BAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
